// File: rtl/traceback_walker_if.sv
// PE-memory read bus between the traceback walker (master) and the PE pointer stores (slave).
// The walker drives a PE select and word address; the pointer byte comes back in the same cycle.
interface traceback_walker_if #(
   parameter int B = 4
);
   logic [$clog2(B)-1:0] pe_id;
   logic [7:0]           addr;
   logic [7:0]           rel_pos;

   modport master (output pe_id, output addr, input rel_pos);
   modport slave  (input pe_id, input addr, output rel_pos);
endinterface

// File: rtl/traceback_walker.sv
// Banded Smith-Waterman traceback: walks stored direction pointers from the max-score cell
// toward the origin and emits one aligned R/Q symbol pair every two cycles.
//
// state    | meaning
// ---------+------------------------------------------------------------
// S_IDLE   | waiting for start; start cell checked against band/length
// S_LOOKUP | pe_id/addr driven for cell (i,j); pointer captured on edge
// S_EMIT   | out_valid high with the pair; next cell computed and checked
// S_DONE   | walk over; finish pulses on the following cycle
module traceback_walker #(
   parameter int             B     = 4,
   parameter int             L     = 8,
   parameter int             SYM_W = 3,
   parameter logic [SYM_W-1:0] GAP = 3'b100
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic                 start,
   input  logic [7:0]           start_i,
   input  logic [7:0]           start_j,
   input  logic [SYM_W*L-1:0]   R_sub,
   input  logic [SYM_W*L-1:0]   Q_sub,
   traceback_walker_if.master   mem,
   output logic [SYM_W-1:0]     out_r,
   output logic [SYM_W-1:0]     out_q,
   output logic                 out_valid,
   output logic                 busy,
   output logic                 finish,
   output logic                 band_err,
   output logic [4:0]           len
);
   localparam int PW = $clog2(B);
   localparam logic [1:0] P_STOP = 2'b00;
   localparam logic [1:0] P_DIAG = 2'b01;
   localparam logic [1:0] P_UP   = 2'b10;
   localparam logic [1:0] P_LEFT = 2'b11;
   localparam logic signed [9:0] HALF_B = 10'(B/2);
   localparam logic signed [9:0] PE_MAX = 10'(B-1);
   localparam logic [4:0] LEN_MAX = 5'(2*L);

   typedef enum logic [1:0] {S_IDLE, S_LOOKUP, S_EMIT, S_DONE} state_t;

   state_t      state;
   logic [7:0]  i, j;
   logic [1:0]  ptr;
   logic [7:0]  ni, nj;
   logic        exhausted;
   logic        start_bad;
   logic [1:0]  rp;

   // Pointer byte upper bits carry no meaning for the walk.
   logic unused_rel_pos;
   assign unused_rel_pos = ^mem.rel_pos[7:2];
   assign rp = mem.rel_pos[1:0];

   function automatic logic in_band(input logic [7:0] ii, input logic [7:0] jj);
      logic signed [9:0] p;
      p = $signed({2'b00, jj}) - $signed({2'b00, ii}) + HALF_B;
      return (p >= 10'sd0) && (p <= PE_MAX);
   endfunction

   function automatic logic [PW-1:0] pe_of(input logic [7:0] ii, input logic [7:0] jj);
      return PW'(jj + 8'(B/2) - ii);
   endfunction

   function automatic logic [SYM_W-1:0] r_sym(input logic [7:0] k);
      return R_sub[SYM_W*(L-1-int'(k)) +: SYM_W];
   endfunction

   function automatic logic [SYM_W-1:0] q_sym(input logic [7:0] k);
      return Q_sub[SYM_W*(L-1-int'(k)) +: SYM_W];
   endfunction

   assign start_bad = (start_i >= 8'(L)) || (start_j >= 8'(L)) || !in_band(start_i, start_j);

   // Successor cell; wrapped values are never used because exhaustion ends the walk first.
   always_comb begin
      ni        = i;
      nj        = j;
      exhausted = 1'b0;
      case (ptr)
         P_DIAG: begin
            exhausted = (i == 8'd0) || (j == 8'd0);
            ni        = i - 8'd1;
            nj        = j - 8'd1;
         end
         P_UP: begin
            exhausted = (j == 8'd0);
            nj        = j - 8'd1;
         end
         P_LEFT: begin
            exhausted = (i == 8'd0);
            ni        = i - 8'd1;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state     <= S_IDLE;
         i         <= '0;
         j         <= '0;
         ptr       <= '0;
         len       <= '0;
         band_err  <= 1'b0;
         out_r     <= '0;
         out_q     <= '0;
         out_valid <= 1'b0;
         mem.pe_id <= '0;
         mem.addr  <= '0;
         busy      <= 1'b0;
         finish    <= 1'b0;
      end else begin
         finish <= 1'b0;
         case (state)
            S_IDLE: begin
               if (start) begin
                  i        <= start_i;
                  j        <= start_j;
                  len      <= '0;
                  busy     <= 1'b1;
                  if (start_bad) begin
                     band_err <= 1'b1;
                     state    <= S_DONE;
                  end else begin
                     band_err  <= 1'b0;
                     mem.pe_id <= pe_of(start_i, start_j);
                     mem.addr  <= start_i;
                     state     <= S_LOOKUP;
                  end
               end
            end
            S_LOOKUP: begin
               ptr       <= rp;
               mem.pe_id <= '0;
               mem.addr  <= '0;
               if (rp == P_STOP) begin
                  state <= S_DONE;
               end else begin
                  out_valid <= 1'b1;
                  out_r     <= (rp == P_UP)   ? GAP : r_sym(i);
                  out_q     <= (rp == P_LEFT) ? GAP : q_sym(j);
                  state     <= S_EMIT;
               end
            end
            S_EMIT: begin
               out_valid <= 1'b0;
               out_r     <= '0;
               out_q     <= '0;
               if (len != LEN_MAX) len <= len + 5'd1;
               if (exhausted) begin
                  state <= S_DONE;
               end else begin
                  i <= ni;
                  j <= nj;
                  if (!in_band(ni, nj)) begin
                     band_err <= 1'b1;
                     state    <= S_DONE;
                  end else begin
                     mem.pe_id <= pe_of(ni, nj);
                     mem.addr  <= ni;
                     state     <= S_LOOKUP;
                  end
               end
            end
            S_DONE: begin
               busy   <= 1'b0;
               finish <= 1'b1;
               state  <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end
endmodule
